// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset fetch address, fetch buffer depth and the
// {pc, inst} entry passed from fetch to decode.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    // Fetch buffer holds this many {pc, inst} entries.
    localparam int unsigned FS_BUF_DEPTH = 2;

    // Width of an entry count that can represent 0..FS_BUF_DEPTH.
    localparam int unsigned FS_CNT_W = $clog2(FS_BUF_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fs_buf.sv
// Two-entry in-order fetch buffer. Entry 0 is always the head. Flush empties
// the buffer and wins over push/pop in the same cycle. Push and pop together
// keep the count unchanged. The request logic upstream guarantees that no
// push arrives when the buffer is already full.
module fs_buf
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                push,
    input  fetch_entry_t        push_data,
    input  logic                pop,
    input  logic                flush,
    output fetch_entry_t        head,
    output logic [FS_CNT_W-1:0] count,
    output logic                valid
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic         do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop & valid;
    assign head   = valid ? entry0 : '0;

    // Entry storage and occupancy; the head shifts down on every pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == '0) begin
                        entry0 <= push_data;
                    end else begin
                        entry1 <= push_data;
                    end
                    count <= count + 1'b1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 1'b1;
                end
                2'b11: begin
                    if (count == FS_CNT_W'(1)) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues at most one read per cycle to a synchronous
// instruction SRAM (data returns the following cycle) and buffers the
// returned {pc, inst} pairs for decode. A request is only issued when the
// buffer is guaranteed to have room for its response, so the buffer never
// overflows and no response is ever dropped except on a redirect.
//
// Handshake: an entry moves to decode in any cycle where fs_to_ds_valid and
// ds_allowin are both 1 (and no redirect is being taken); it is removed on
// the clock edge ending that cycle. fs_pc/fs_inst stay stable while
// fs_to_ds_valid=1 and ds_allowin=0, unless br_taken flushes the stage.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    localparam logic [FS_CNT_W:0] DEPTH_L = (FS_CNT_W + 1)'(FS_BUF_DEPTH);

    logic [31:0]         req_pc;
    logic [31:0]         issued_addr;
    logic                inflight;
    logic                pop;
    logic                push;
    logic                buf_valid;
    logic [FS_CNT_W-1:0] buf_count;
    logic [FS_CNT_W:0]   occupancy;
    fetch_entry_t        push_data;
    fetch_entry_t        head;
    logic                unused_bits;

    // Low address bits are never used: fetch is always word aligned.
    assign unused_bits = ^{br_target[1:0], req_pc[1:0]};

    // A redirect takes priority over handing the head entry to decode.
    assign pop = buf_valid & ds_allowin & ~br_taken;

    // Entries held after this cycle's pop, counting the response still due.
    assign occupancy = {1'b0, buf_count}
                     + {{FS_CNT_W{1'b0}}, inflight}
                     - {{FS_CNT_W{1'b0}}, pop};

    // Request only while out of reset; a redirect always fetches its target.
    assign inst_sram_en    = resetn & (br_taken | (occupancy < DEPTH_L));
    assign inst_sram_addr  = br_taken ? {br_target[31:2], 2'b00} : {req_pc[31:2], 2'b00};
    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = 32'h0;

    // A response arriving together with a redirect belongs to the old path.
    assign push           = inflight & ~br_taken;
    assign push_data.pc   = issued_addr;
    assign push_data.inst = inst_sram_rdata;

    assign fs_to_ds_valid = buf_valid;
    assign fs_pc          = head.pc;
    assign fs_inst        = head.inst;

    // Next sequential fetch address and the tag of the request in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_pc      <= RESET_PC;
            issued_addr <= '0;
            inflight    <= 1'b0;
        end else if (inst_sram_en) begin
            req_pc      <= inst_sram_addr + 32'd4;
            issued_addr <= inst_sram_addr;
            inflight    <= 1'b1;
        end else begin
            inflight    <= 1'b0;
        end
    end

    fs_buf u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (br_taken),
        .head      (head),
        .count     (buf_count),
        .valid     (buf_valid)
    );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h1c000000, first fetch address after reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- br_taken  in  1  redirect pulse from execute.
- br_target  in  32  redirect address.
- ds_allowin  in  1  decode can accept this cycle.
- inst_sram_en  out  1  read request.
- inst_sram_we  out  1  tied 0.
- inst_sram_addr  out  32  request address.
- inst_sram_wdata  out  32  tied 0.
- inst_sram_rdata  in  32  read data, valid one cycle after an accepted request.
- fs_to_ds_valid  out  1  head entry valid.
- fs_pc  out  32  head entry PC.
- fs_inst  out  32  head entry instruction.

Function
REQ-003 SHALL hold registered next-request PC req_pc, an in-flight flag, and a 2-entry FIFO of {pc, inst}.
REQ-004 SHALL assume a synchronous instruction SRAM: a request with en=1 in cycle N returns rdata in cycle N+1, unconditionally.
REQ-005 SHALL define pop = fs_to_ds_valid & ds_allowin; the head entry SHALL be removed on the clk edge ending a pop cycle.
REQ-006 SHALL assert inst_sram_en when br_taken=1, or when (count + inflight - pop) < 2.
REQ-007 SHALL drive inst_sram_addr = {br_target[31:2],2'b00} when br_taken=1, else req_pc; bits [1:0] SHALL always be 00.
REQ-008 SHALL, on every issued request, update req_pc to issued address + 4 (mod 2^32) and set inflight=1; with no request, inflight SHALL clear.
REQ-009 SHALL, in the cycle a returning response arrives and is not discarded, push {issued addr, inst_sram_rdata} into the FIFO.
REQ-010 SHALL, when br_taken=1: clear the FIFO, discard any response arriving that same cycle, and suppress pop. The response to the br_target request SHALL be kept.
REQ-011 SHALL support push and pop in the same cycle; count is unchanged.
REQ-012 SHALL never overflow the FIFO. REQ-006 guarantees this, and the bench SHALL check it with an assertion.
REQ-013 SHALL, with ds_allowin held 1, sustain one instruction per cycle after a 2-cycle initial latency.
REQ-014 SHALL drive fs_to_ds_valid = (count != 0); fs_pc/fs_inst SHALL show the head entry, or 0 when empty.
REQ-015 SHALL hold fs_pc/fs_inst stable while fs_to_ds_valid=1 and ds_allowin=0, except after br_taken.

Reset
REQ-016 SHALL, while resetn=0: req_pc=RESET_PC, inflight=0, count=0, inst_sram_en=0, fs_to_ds_valid=0, fs_pc=0, fs_inst=0.
REQ-017 SHALL issue the first request to RESET_PC in the first cycle after resetn deasserts.
REQ-018 SHALL, on reset asserted mid-operation, drop the FIFO and the in-flight request; no stale response SHALL be pushed after release.

Structure
REQ-019 SHALL take RESET_PC default and the FIFO depth constant (2) from the shared cpu package, alongside the fetch-entry typedef {pc[31:0], inst[31:0]}.
REQ-020 SHALL place the 2-entry FIFO in one sub-module, fs_buf, with push/pop/flush/count; the request logic stays in if_stage.

Verification
REQ-021 Reset release, ds_allowin=1, SRAM returns addr as data -> requests 0x1c000000, 0x1c000004, ...; fs_pc=0x1c000000 valid at cycle 2; one per cycle thereafter.
REQ-022 Hold ds_allowin=0 from cycle 2 -> FIFO fills to 2 and inst_sram_en drops to 0; fs_pc stays 0x1c000000. On release: 0x1c000000, 0x1c000004, 0x1c000008 emitted with no gaps and none lost.
REQ-023 br_taken=1, br_target=0x1c000100, while FIFO full and request in flight -> next valid fs_pc=0x1c000100, then 0x1c000104; no old PC emitted.
REQ-024 br_target=0x1c000203 -> inst_sram_addr=0x1c000200, fs_pc=0x1c000200.
REQ-025 resetn pulsed low mid-stream with inflight=1 -> outputs zero immediately. After release the first fs_pc is 0x1c000000.
REQ-026 Random ds_allowin/br_taken for 10k cycles against a reference PC model -> in-order PCs, no duplicates or drops, FIFO count never exceeds 2.
